// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, processor ID, handler address and exception codes.
package cp0_pkg;

    localparam logic [4:0]  REG_SR       = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  REG_PRID     = 5'd15;

    localparam logic [31:0] PRID         = 32'h0000_2016;
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Return address for a faulting instruction; a delay-slot victim restarts at its branch.
    function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
        logic [31:0] aligned;
        aligned = {pc[31:2], 2'b00};
        return bd ? aligned - 32'd4 : aligned;
    endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception request generation, mtc0/mfc0 access.
module cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (ExcIn != 5'd0) & ~sr_exl;
    assign Req     = int_req | exc_req;

    // mtc0 is dropped whenever the victim is being flushed this cycle
    assign wr_sr   = We & (A2 == REG_SR)  & ~Req;
    assign wr_epc  = We & (A2 == REG_EPC) & ~Req;

    assign EPCOut  = wr_epc ? DIn : epc;

    assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc;
            REG_PRID:  DOut = PRID;
            default:   DOut = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= BD;
                cause_exc <= int_req ? EXC_INT : ExcIn;
                epc       <= victim_epc(PC, BD);
            end else begin
                if (wr_sr) begin
                    sr_im  <= DIn[15:10];
                    sr_exl <= DIn[1];
                    sr_ie  <= DIn[0];
                end
                if (wr_epc) begin
                    epc <= DIn;
                end
                // eret takes precedence over an mtc0 SR write for the EXL bit
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus randomized traffic against a word-level model.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    int checks = 0;
    int errors = 0;

    // Architectural state held as whole 32-bit register images
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0 dut (
        .clk    (clk),
        .reset  (reset),
        .A1     (A1),
        .A2     (A2),
        .DIn    (DIn),
        .We     (We),
        .PC     (PC),
        .BD     (BD),
        .ExcIn  (ExcIn),
        .HWInt  (HWInt),
        .EXLClr (EXLClr),
        .Req    (Req),
        .EPCOut (EPCOut),
        .DOut   (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_2016;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_intreq();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_intreq() || ((ExcIn != 5'd0) && !m_sr[1]);
    endfunction

    // Check outputs mid-cycle against the model, then advance model and DUT by one edge.
    task automatic cycle();
        logic        r;
        logic [31:0] n_sr, n_cause, n_epc, pc_al;
        @(negedge clk);
        r = m_req();
        chk("req", {31'd0, Req}, {31'd0, r});
        chk("epcout", EPCOut, (We && A2 == 5'd14 && !r) ? DIn : m_epc);
        chk("dout", DOut, m_read(A1));
        n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
        if (!reset) begin
            n_sr = 0; n_cause = 0; n_epc = 0;
        end else begin
            n_cause = (n_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
            if (r) begin
                n_sr = n_sr | 32'h2;
                n_cause = (n_cause & ~32'h8000_007C) | ({31'd0, BD} << 31)
                        | ({27'd0, (m_intreq() ? 5'd0 : ExcIn)} << 2);
                pc_al = PC & ~32'd3;
                n_epc = BD ? pc_al - 32'd4 : pc_al;
            end else begin
                if (We && A2 == 5'd12) n_sr = DIn & 32'h0000_FC03;
                if (We && A2 == 5'd14) n_epc = DIn;
                if (EXLClr) n_sr = n_sr & ~32'h2;
            end
        end
        @(posedge clk);
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        chk(tag, DOut, exp);
    endtask

    task automatic idle();
        We = 0; EXLClr = 0; ExcIn = 0; BD = 0;
    endtask

    initial begin
        m_sr = 0; m_cause = 0; m_epc = 0;
        reset = 0; A1 = 0; A2 = 0; DIn = 0; We = 0; PC = 0; BD = 0;
        ExcIn = 0; HWInt = 0; EXLClr = 0;
        @(posedge clk); #1;
        cycle();
        reset = 1;

        // Reset state
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h0000_2016);
        chk("rst_req", {31'd0, Req}, 32'd0);

        // Interrupt taken right after enabling
        We = 1; A2 = 5'd12; DIn = 32'h0000_0401;
        cycle();
        idle(); HWInt = 6'b000001; PC = 32'h0000_3010;
        #1 chk("int_req_now", {31'd0, Req}, 32'd1);
        cycle();
        HWInt = 0;
        rd("int_epc", 5'd14, 32'h0000_3010);
        rd("int_sr", 5'd12, 32'h0000_0403);
        rd("int_cause", 5'd13, 32'h0000_0400);
        chk("int_req_after", {31'd0, Req}, 32'd0);

        // Overflow in a delay slot
        EXLClr = 1; cycle(); idle();
        ExcIn = 5'd12; BD = 1; PC = 32'h0000_3024;
        #1 chk("ov_req_now", {31'd0, Req}, 32'd1);
        cycle(); idle();
        rd("ov_epc", 5'd14, 32'h0000_3020);
        rd("ov_cause", 5'd13, 32'h8000_0030);

        // Interrupt beats RI, and the concurrent mtc0 EPC is dropped
        EXLClr = 1; cycle(); idle();
        HWInt = 6'b000001; ExcIn = 5'd10; We = 1; A2 = 5'd14; DIn = 32'hDEAD_BEEC; PC = 32'h0000_3040;
        #1 chk("pri_epcout", EPCOut, 32'h0000_3020);
        cycle(); idle(); HWInt = 0;
        rd("pri_epc", 5'd14, 32'h0000_3040);
        rd("pri_cause", 5'd13, 32'h0000_0400);

        // mtc0 EPC bypass into eret
        We = 1; A2 = 5'd14; DIn = 32'h0000_3100; EXLClr = 1;
        #1 chk("byp_epcout", EPCOut, 32'h0000_3100);
        cycle(); idle();
        rd("byp_sr", 5'd12, 32'h0000_0401);
        rd("byp_epc", 5'd14, 32'h0000_3100);

        // No nesting while EXL is set; EXLClr beats an SR write setting EXL
        We = 1; A2 = 5'd12; DIn = 32'h0000_0403; cycle(); idle();
        HWInt = 6'b000001;
        #1 chk("nest_req0", {31'd0, Req}, 32'd0);
        cycle();
        We = 1; A2 = 5'd12; DIn = 32'h0000_0403; EXLClr = 1;
        #1 chk("nest_req1", {31'd0, Req}, 32'd0);
        cycle(); idle();
        rd("clr_wins_sr", 5'd12, 32'h0000_0401);
        chk("nest_req2", {31'd0, Req}, 32'd1);
        PC = 32'h0000_3200;
        cycle(); HWInt = 0;

        // EPC wraps below zero
        EXLClr = 1; cycle(); idle();
        ExcIn = 5'd4; BD = 1; PC = 32'h0000_0002;
        cycle(); idle();
        rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);

        // Reset overrides concurrent write and eret
        reset = 0; We = 1; A2 = 5'd14; DIn = 32'h1234_5678; EXLClr = 1; HWInt = 6'h3F;
        cycle(); reset = 1; idle(); HWInt = 0;
        rd("rst2_epc", 5'd14, 32'h0);
        rd("rst2_sr", 5'd12, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(0, 40) != 0);
            A1     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            A2     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            DIn    = $urandom;
            if ($urandom_range(0, 1) == 0) DIn[1] = 1'b0;
            We     = ($urandom_range(0, 2) == 0);
            PC     = $urandom;
            BD     = 1'($urandom);
            ExcIn  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            HWInt  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            EXLClr = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1: synchronous, active-low (0 = reset), sampled on posedge clk.
REQ-003 SHALL have port A1, input, 5: read register index.
REQ-004 SHALL have port A2, input, 5: write register index.
REQ-005 SHALL have port DIn, input, 32: mtc0 write data.
REQ-006 SHALL have port We, input, 1: mtc0 write enable.
REQ-007 SHALL have port PC, input, 32: PC of the instruction currently in the M stage (victim PC).
REQ-008 SHALL have port BD, input, 1: victim instruction is in a branch delay slot.
REQ-009 SHALL have port ExcIn, input, 5: exception code of the victim; 0 = no exception.
REQ-010 SHALL have port HWInt, input, 6: hardware interrupt lines [7:2], level-sensitive.
REQ-011 SHALL have port EXLClr, input, 1: eret in M stage.
REQ-012 SHALL have port Req, output, 1: take exception/interrupt this cycle (flush pipeline, PC <= handler).
REQ-013 SHALL have port EPCOut, output, 32: return address for eret.
REQ-014 SHALL have port DOut, output, 32: mfc0 read data.

Function
REQ-015 SHALL implement SR (12: IM[15:10], EXL[1], IE[0]), Cause (13: BD[31], IP[15:10], ExcCode[6:2]), EPC (14), PRId (15, constant 32'h0000_2016); all other indices read 0.
REQ-016 SHALL compute IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL, combinationally from registered SR and live HWInt.
REQ-017 SHALL compute ExcReq = (ExcIn != 0) & ~SR.EXL; Req = IntReq | ExcReq, combinational, same cycle.
REQ-018 SHALL give interrupt priority over exception when both are pending: ExcCode <= 0 (Int); otherwise ExcCode <= ExcIn.
REQ-019 SHALL on Req at the next edge: EXL <= 1; Cause.BD <= BD; EPC <= BD ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
REQ-020 SHALL update Cause.IP <= HWInt on every non-reset edge, regardless of Req/EXL.
REQ-021 SHALL on We without Req write DIn to SR (A2=12) or EPC (A2=14); writes to 13, 15, or others are ignored.
REQ-022 SHALL ignore We entirely in a cycle where Req=1.
REQ-023 SHALL on EXLClr clear EXL at the next edge; if same-cycle We targets SR, EXLClr wins for bit EXL and the remaining SR bits take DIn.
REQ-024 SHALL keep Req=0 while EXL=1 (no nesting); Req while EXLClr=1 is impossible because EXL=1 that cycle.
REQ-025 SHALL drive DOut = register[A1] combinationally from registered state (no write bypass).
REQ-026 SHALL drive EPCOut = DIn when We & (A2==14) & ~Req, else EPC register (bypass for mtc0 immediately before eret).
REQ-027 SHALL wrap EPC subtraction mod 2^32 (PC=0 with BD=1 gives 32'hFFFF_FFFC).

Reset
REQ-028 SHALL on reset=0 at a posedge clear SR, Cause, EPC to 0; PRId is unaffected (constant).
REQ-029 SHALL hold Req=0 during the reset cycle's effect: after reset, EXL=0, IE=0, so Req stays 0 until software sets IE/IM.
REQ-030 SHALL let reset override Req, We, and EXLClr in the same cycle.

Structure
REQ-031 SHALL place register indices (12-15), PRID value, HANDLER_ADDR 32'h0000_4180, and ExcCode values (Int=0, AdEL=4, AdES=5, RI=10, Ov=12) in shared package cp0_pkg.
REQ-032 SHALL be a single flat module with no sub-modules; the handler redirect mux stays in the PC-select logic, not in cp0.

Verification
REQ-033 SHALL check: reset=0 for one edge -> DOut reads SR=0, Cause=0, EPC=0, A1=15 reads 32'h0000_2016, Req=0.
REQ-034 SHALL check: mtc0 SR=32'h0000_0401, HWInt=6'b000001, PC=32'h0000_3010, BD=0 -> Req=1 same cycle; next: EPC=32'h0000_3010, EXL=1, ExcCode=0, Req=0.
REQ-035 SHALL check: ExcIn=12, BD=1, PC=32'h0000_3024, HWInt=0 -> Req=1; next: EPC=32'h0000_3020, Cause.BD=1, ExcCode=12.
REQ-036 SHALL check: IntReq and ExcIn=10 in same cycle with We=1 A2=14 DIn=32'hDEAD_BEEC -> ExcCode=0, EPC=victim PC, We ignored.
REQ-037 SHALL check: EXL=1, We=1 A2=14 DIn=32'h0000_3100 with EXLClr=1 -> EPCOut=32'h0000_3100 same cycle; next: EXL=0, EPC=32'h0000_3100.
REQ-038 SHALL check: EXL=1 and HWInt pending with IM/IE set -> Req=0 until EXLClr; the cycle after EXL clears -> Req=1.
